// File: rtl/conv_window_sched_pkg.sv
// Shared types and constants for the convolution window scheduler.
package conv_window_sched_pkg;

  localparam int COLUMN_FIFO_DEPTH = 8;
  localparam int K_MAX             = 7;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    FILL,
    STREAM,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/conv_window_sched_row_fetch_unit.sv
// Row prefetch engine: issues SRAM row reads while the column FIFO has room.
module row_fetch_unit
  import conv_window_sched_pkg::*;
#(
  parameter int DEPTH = COLUMN_FIFO_DEPTH,
  parameter int H_W   = 8
) (
  input  logic           clk_i,
  input  logic           rst_async_n_i,
  input  logic           i_en,
  input  logic           i_clear,
  input  logic [H_W:0]   i_img_h,
  input  logic [H_W:0]   i_occ,
  input  logic           i_fifo_full,
  input  logic           i_rvalid,
  output logic           o_req,
  output logic [H_W-1:0] o_addr,
  output logic           o_push
);

  localparam logic [H_W+1:0] DEPTH_W = (H_W+2)'(DEPTH);

  logic [H_W:0] r_fetched;
  logic [H_W:0] r_outstanding;
  logic         w_room;

  // Rows in flight are counted against capacity so a late push can never overfill.
  assign w_room = ({1'b0, i_occ} + {1'b0, r_outstanding}) < DEPTH_W;
  assign o_req  = i_en && (r_fetched < i_img_h) && w_room && !i_fifo_full;
  assign o_addr = r_fetched[H_W-1:0];
  assign o_push = i_en && i_rvalid;

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_fetched     <= '0;
      r_outstanding <= '0;
    end else if (i_clear) begin
      r_fetched     <= '0;
      r_outstanding <= '0;
    end else begin
      if (o_req) r_fetched <= r_fetched + (H_W+1)'(1);
      case ({o_req, o_push})
        2'b10:   r_outstanding <= r_outstanding + (H_W+1)'(1);
        2'b01:   r_outstanding <= r_outstanding - (H_W+1)'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// Sequences K-row windows from SRAM through the column FIFO into the systolic array.
module conv_window_sched
  import conv_window_sched_pkg::*;
#(
  parameter int DEPTH = COLUMN_FIFO_DEPTH,
  parameter int H_W   = 8
) (
  input  logic           clk_i,
  input  logic           rst_async_n_i,
  input  logic           start_i,
  input  logic [H_W-1:0] cfg_img_h_i,
  input  logic [2:0]     cfg_k_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic           sram_req_o,
  output logic [H_W-1:0] sram_addr_o,
  input  logic           sram_rvalid_i,
  input  logic           sa_ready_i,
  output logic           fifo_flush_o,
  output logic           fifo_push_o,
  output logic           fifo_pop_o,
  output logic           fifo_shift_o,
  input  logic           fifo_full_i,
  input  logic           fifo_empty_i,
  output logic [H_W-1:0] out_row_o
);

  state_e       r_state, w_state_nxt;
  logic [H_W:0] r_img_h, r_k, r_occ, r_pops, r_out_row;
  logic         r_err;
  logic [H_W:0] w_k_cfg, w_occ_nxt, w_out_row_nxt, w_last_row;
  logic         w_start_ok, w_fetch_en, w_push, w_pop, w_last_pop;

  assign w_k_cfg    = (H_W+1)'(cfg_k_i);
  assign w_start_ok = (cfg_k_i != 3'd0) && (int'(cfg_k_i) <= K_MAX) &&
                      (int'(cfg_k_i) <= DEPTH) && (w_k_cfg <= {1'b0, cfg_img_h_i});

  assign w_pop         = (r_state == STREAM) && sa_ready_i && !fifo_empty_i;
  assign w_last_pop    = w_pop && (r_pops == r_k - (H_W+1)'(1));
  assign w_occ_nxt     = r_occ + (H_W+1)'(w_push) - (H_W+1)'(fifo_shift_o);
  assign w_out_row_nxt = r_out_row + (H_W+1)'(1);
  assign w_last_row    = r_img_h - r_k + (H_W+1)'(1);

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start_i && w_start_ok) w_state_nxt = FLUSH;
      FLUSH:  w_state_nxt = FILL;
      FILL:   if (r_occ >= r_k) w_state_nxt = STREAM;
      STREAM: if (w_last_pop) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_out_row_nxt == w_last_row) w_state_nxt = DONE;
        else if (w_occ_nxt >= r_k)       w_state_nxt = STREAM;
        else                             w_state_nxt = FILL;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (r_state != IDLE);
    done_o       = (r_state == DONE);
    fifo_flush_o = (r_state == FLUSH);
    fifo_shift_o = (r_state == SHIFT);
    fifo_pop_o   = w_pop;
    w_fetch_en   = (r_state == FILL) || (r_state == STREAM) || (r_state == SHIFT);
  end

  // Occupancy counts pushed minus shifted rows; pops only read the window.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_img_h   <= '0;
      r_k       <= '0;
      r_occ     <= '0;
      r_pops    <= '0;
      r_out_row <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && start_i && !w_start_ok;
      if ((r_state == IDLE) && start_i && w_start_ok) begin
        r_img_h <= {1'b0, cfg_img_h_i};
        r_k     <= w_k_cfg;
      end
      if (fifo_flush_o) begin
        r_occ     <= '0;
        r_pops    <= '0;
        r_out_row <= '0;
      end else begin
        r_occ <= w_occ_nxt;
        if (w_pop)        r_pops    <= w_last_pop ? '0 : r_pops + (H_W+1)'(1);
        if (fifo_shift_o) r_out_row <= w_out_row_nxt;
      end
    end
  end

  assign err_o       = r_err;
  assign out_row_o   = r_out_row[H_W-1:0];
  assign fifo_push_o = w_push;

  row_fetch_unit #(
    .DEPTH (DEPTH),
    .H_W   (H_W)
  ) u_fetch (
    .clk_i         (clk_i),
    .rst_async_n_i (rst_async_n_i),
    .i_en          (w_fetch_en),
    .i_clear       (fifo_flush_o),
    .i_img_h       (r_img_h),
    .i_occ         (r_occ),
    .i_fifo_full   (fifo_full_i),
    .i_rvalid      (sram_rvalid_i),
    .o_req         (sram_req_o),
    .o_addr        (sram_addr_o),
    .o_push        (w_push)
  );

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched with a 1-cycle SRAM model and a counting FIFO model.
module tb_conv_window_sched;

  localparam int DEPTH = 4;
  localparam int H_W   = 8;

  logic           clk_i = 1'b0;
  logic           rst_async_n_i = 1'b0;
  logic           start_i = 1'b0;
  logic [H_W-1:0] cfg_img_h_i = '0;
  logic [2:0]     cfg_k_i = '0;
  logic           busy_o, done_o, err_o, sram_req_o;
  logic [H_W-1:0] sram_addr_o, out_row_o;
  logic           sram_rvalid_i, sa_ready_i;
  logic           fifo_flush_o, fifo_push_o, fifo_pop_o, fifo_shift_o;
  logic           fifo_full_i, fifo_empty_i;

  int n_cmp = 0;
  int n_bad = 0;
  bit sa_toggle = 1'b0;
  int fifo_cnt;

  int m_req, m_pop, m_shift, m_done, m_flush, m_err, m_busy, m_push;
  int m_max, m_pushfull, m_popshift;
  int addr_q[$];
  int row_q[$];

  conv_window_sched #(.DEPTH(DEPTH), .H_W(H_W)) dut (
    .clk_i         (clk_i),
    .rst_async_n_i (rst_async_n_i),
    .start_i       (start_i),
    .cfg_img_h_i   (cfg_img_h_i),
    .cfg_k_i       (cfg_k_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .sram_req_o    (sram_req_o),
    .sram_addr_o   (sram_addr_o),
    .sram_rvalid_i (sram_rvalid_i),
    .sa_ready_i    (sa_ready_i),
    .fifo_flush_o  (fifo_flush_o),
    .fifo_push_o   (fifo_push_o),
    .fifo_pop_o    (fifo_pop_o),
    .fifo_shift_o  (fifo_shift_o),
    .fifo_full_i   (fifo_full_i),
    .fifo_empty_i  (fifo_empty_i),
    .out_row_o     (out_row_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      sram_rvalid_i <= 1'b0;
      fifo_cnt      <= 0;
      sa_ready_i    <= 1'b1;
    end else begin
      sram_rvalid_i <= sram_req_o;
      if (fifo_flush_o) fifo_cnt <= 0;
      else              fifo_cnt <= fifo_cnt + int'(fifo_push_o) - int'(fifo_shift_o);
      sa_ready_i <= sa_toggle ? ~sa_ready_i : 1'b1;
    end
  end

  assign fifo_full_i  = (fifo_cnt >= DEPTH);
  assign fifo_empty_i = (fifo_cnt == 0);

  always @(negedge clk_i) begin
    if (rst_async_n_i) begin
      if (sram_req_o) begin m_req++; addr_q.push_back(int'(sram_addr_o)); end
      if (fifo_pop_o) begin m_pop++; row_q.push_back(int'(out_row_o)); end
      if (fifo_shift_o) m_shift++;
      if (done_o) m_done++;
      if (fifo_flush_o) m_flush++;
      if (err_o) m_err++;
      if (busy_o) m_busy++;
      if (fifo_push_o) m_push++;
      if (fifo_push_o && fifo_full_i) m_pushfull++;
      if (fifo_pop_o && fifo_shift_o) m_popshift++;
      if (fifo_cnt > m_max) m_max = fifo_cnt;
    end
  end

  task automatic clear_mon();
    m_req = 0; m_pop = 0; m_shift = 0; m_done = 0; m_flush = 0; m_err = 0;
    m_busy = 0; m_push = 0; m_max = 0; m_pushfull = 0; m_popshift = 0;
    addr_q.delete();
    row_q.delete();
  endtask

  task automatic start_job(input int h, input int k);
    @(posedge clk_i); #1;
    cfg_img_h_i = H_W'(h);
    cfg_k_i     = 3'(k);
    start_i     = 1'b1;
    @(posedge clk_i); #1;
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && m_done == 0; i++) @(posedge clk_i);
    #1;
    n_cmp++;
    if (m_done == 0) begin
      n_bad++;
      $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_async_n_i = 1'b0;
    start_i = 1'b1; cfg_img_h_i = 8'd5; cfg_k_i = 3'd3;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({busy_o, done_o, err_o, sram_req_o, fifo_flush_o, fifo_push_o, fifo_pop_o,
         fifo_shift_o, sram_addr_o, out_row_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b req=%b flush=%b addr=%0d row=%0d, all required 0",
               busy_o, done_o, err_o, sram_req_o, fifo_flush_o, sram_addr_o, out_row_o);
    end
    start_i = 1'b0;
    #2 rst_async_n_i = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (m_busy !== 0) begin
      n_bad++;
      $display("FAIL reset_idle_busy: busy cycles %0d, required 0", m_busy);
    end
  endtask

  task automatic test_basic();
    clear_mon();
    start_job(5, 3);
    wait_done("basic", 300);
    n_cmp++;
    if (m_req !== 5) begin n_bad++; $display("FAIL basic_req: got %0d required 5", m_req); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= addr_q.size() || addr_q[i] !== i) begin
        n_bad++;
        $display("FAIL basic_addr%0d: got %0d required %0d", i, (i < addr_q.size()) ? addr_q[i] : -1, i);
      end
    end
    n_cmp++;
    if (m_pop !== 9) begin n_bad++; $display("FAIL basic_pop: got %0d required 9", m_pop); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (i >= row_q.size() || row_q[i] !== i / 3) begin
        n_bad++;
        $display("FAIL basic_out_row_pop%0d: got %0d required %0d", i, (i < row_q.size()) ? row_q[i] : -1, i / 3);
      end
    end
    n_cmp++;
    if (m_shift !== 3) begin n_bad++; $display("FAIL basic_shift: got %0d required 3", m_shift); end
    n_cmp++;
    if (m_done !== 1) begin n_bad++; $display("FAIL basic_done: got %0d required 1", m_done); end
    n_cmp++;
    if (m_flush !== 1) begin n_bad++; $display("FAIL basic_flush: got %0d required 1", m_flush); end
    n_cmp++;
    if (m_push !== 5) begin n_bad++; $display("FAIL basic_push: got %0d required 5", m_push); end
  endtask

  task automatic test_reject();
    int hs[3] = '{5, 4, 10};
    int ks[3] = '{0, 6, 5};
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      start_job(hs[t], ks[t]);
      repeat (4) @(posedge clk_i);
      #1;
      n_cmp++;
      if (m_err !== 1) begin n_bad++; $display("FAIL reject%0d_err: got %0d pulses required 1", t, m_err); end
      n_cmp++;
      if (m_busy + m_flush + m_push + m_pop + m_shift + m_req !== 0) begin
        n_bad++;
        $display("FAIL reject%0d_quiet: busy=%0d flush=%0d req=%0d pop=%0d shift=%0d required all 0",
                 t, m_busy, m_flush, m_req, m_pop, m_shift);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    sa_toggle = 1'b1;
    start_job(10, 3);
    wait_done("bp", 1000);
    sa_toggle = 1'b0;
    n_cmp++;
    if (m_max > DEPTH) begin n_bad++; $display("FAIL bp_occ: max %0d required <= %0d", m_max, DEPTH); end
    n_cmp++;
    if (m_pushfull !== 0) begin n_bad++; $display("FAIL bp_push_full: got %0d required 0", m_pushfull); end
    n_cmp++;
    if (m_popshift !== 0) begin n_bad++; $display("FAIL bp_pop_shift: got %0d required 0", m_popshift); end
    n_cmp++;
    if (m_req !== 10) begin n_bad++; $display("FAIL bp_req: got %0d required 10", m_req); end
    n_cmp++;
    if (m_pop !== 24) begin n_bad++; $display("FAIL bp_pop: got %0d required 24", m_pop); end
    n_cmp++;
    if (m_shift !== 8) begin n_bad++; $display("FAIL bp_shift: got %0d required 8", m_shift); end
    n_cmp++;
    if (m_done !== 1) begin n_bad++; $display("FAIL bp_done: got %0d required 1", m_done); end
  endtask

  task automatic test_reset_mid();
    int i;
    clear_mon();
    start_job(5, 3);
    i = 0;
    while (i < 300 && m_pop < 4) begin @(posedge clk_i); i++; end
    n_cmp++;
    if (m_pop < 4) begin n_bad++; $display("FAIL midrst_reach: pops %0d required >= 4", m_pop); end
    @(negedge clk_i);
    #2 rst_async_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, done_o, err_o, sram_req_o, fifo_flush_o, fifo_push_o, fifo_pop_o,
         fifo_shift_o, sram_addr_o, out_row_o} !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: busy=%b pop=%b req=%b addr=%0d row=%0d, all required 0",
               busy_o, fifo_pop_o, sram_req_o, sram_addr_o, out_row_o);
    end
    repeat (3) @(posedge clk_i);
    #1 rst_async_n_i = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk_i);
    #1;
    n_cmp++;
    if (m_done !== 0 || m_busy !== 0) begin
      n_bad++;
      $display("FAIL midrst_abandon: done=%0d busy=%0d required 0 and 0", m_done, m_busy);
    end
    clear_mon();
    start_job(5, 3);
    #1;
    n_cmp++;
    if (fifo_flush_o !== 1'b1) begin n_bad++; $display("FAIL midrst_flush: got %b required 1", fifo_flush_o); end
    wait_done("midrst_restart", 300);
    n_cmp++;
    if (addr_q.size() == 0 || addr_q[0] !== 0 || m_req !== 5) begin
      n_bad++;
      $display("FAIL midrst_restart_fetch: reqs %0d first addr %0d required 5 and 0",
               m_req, (addr_q.size() > 0) ? addr_q[0] : -1);
    end
    n_cmp++;
    if (m_done !== 1) begin n_bad++; $display("FAIL midrst_restart_done: got %0d required 1", m_done); end
  endtask

  task automatic test_k1();
    clear_mon();
    start_job(1, 1);
    wait_done("k1", 100);
    n_cmp++;
    if ({m_req, m_pop, m_shift, m_done} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL k1_counts: req=%0d pop=%0d shift=%0d done=%0d required 1 each", m_req, m_pop, m_shift, m_done);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    start_job(5, 3);
    repeat (6) @(posedge clk_i);
    #1;
    cfg_img_h_i = 8'd2; cfg_k_i = 3'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("b2b", 300);
    repeat (30) @(posedge clk_i);
    #1;
    n_cmp++;
    if (m_done !== 1) begin n_bad++; $display("FAIL b2b_done: got %0d required 1", m_done); end
    n_cmp++;
    if (m_err !== 0) begin n_bad++; $display("FAIL b2b_err: got %0d required 0", m_err); end
    n_cmp++;
    if (m_flush !== 1 || m_shift !== 3 || m_req !== 5) begin
      n_bad++;
      $display("FAIL b2b_seq: flush=%0d shift=%0d req=%0d required 1, 3, 5", m_flush, m_shift, m_req);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_reject();
    test_backpressure();
    test_reset_mid();
    test_k1();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
CONV_WINDOW_SCHED -- requirements
Module: conv_window_sched

Interface
REQ-001 Parameter DEPTH, default COLUMN_FIFO_DEPTH: capacity in rows of the sequenced column FIFO.
REQ-002 Parameter H_W, default 8: width of row counts and row addresses.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_async_n_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  one-cycle job start; sampled only in IDLE.
REQ-006 cfg_img_h_i  input  H_W  input image height in rows; latched at accepted start.
REQ-007 cfg_k_i  input  3  kernel height K; legal range 1..7; latched at accepted start.
REQ-008 busy_o  output  1  high from accepted start until done_o, inclusive.
REQ-009 done_o  output  1  one-cycle pulse after the last window shift.
REQ-010 err_o  output  1  one-cycle pulse on a rejected start.
REQ-011 sram_req_o  output  1  row read request; fixed read latency of 1 cycle.
REQ-012 sram_addr_o  output  H_W  row index of the current request.
REQ-013 sram_rvalid_i  input  1  read data valid, 1 cycle after sram_req_o.
REQ-014 sa_ready_i  input  1  systolic array accepts one wavefront element this cycle.
REQ-015 fifo_flush_o, fifo_push_o, fifo_pop_o, fifo_shift_o  output  1 each  FIFO control strobes.
REQ-016 fifo_full_i, fifo_empty_i  input  1 each  FIFO status.
REQ-017 out_row_o  output  H_W  index of the output row currently streaming.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, FLUSH, FILL, STREAM, SHIFT and DONE.
REQ-019 A start in IDLE with 1<=K<=7, K<=cfg_img_h_i and K<=DEPTH SHALL be accepted and SHALL cause a transition to FLUSH; any other start in IDLE SHALL pulse err_o and SHALL leave the FSM in IDLE.
REQ-020 start_i outside IDLE SHALL be ignored and SHALL have no effect.
REQ-021 FLUSH SHALL assert fifo_flush_o for exactly 1 cycle, SHALL clear all counters, and SHALL then transition to FILL.
REQ-022 The fetch engine (FILL, STREAM, SHIFT) SHALL assert sram_req_o when fetched < img_h, occ + outstanding < DEPTH, and fifo_full_i=0, with sram_addr_o = fetched; fetched SHALL increment per request.
REQ-023 Each sram_rvalid_i SHALL assert fifo_push_o in the same cycle and SHALL increment occ; at most 1 request SHALL be outstanding per cycle.
REQ-024 occ SHALL equal the rows pushed minus the shifts issued; occ SHALL never exceed DEPTH.
REQ-025 FILL SHALL transition to STREAM when occ >= K.
REQ-026 STREAM SHALL assert fifo_pop_o only when sa_ready_i=1, SHALL issue exactly K pops, and SHALL transition to SHIFT on the cycle of the K-th pop.
REQ-027 SHIFT SHALL assert fifo_shift_o for exactly 1 cycle, SHALL decrement occ by 1 (net of any same-cycle push), and SHALL increment out_row_o.
REQ-028 After SHIFT, the FSM SHALL transition to DONE if out_row = img_h-K+1; otherwise it SHALL transition to STREAM if occ >= K, else to FILL.
REQ-029 fifo_pop_o and fifo_shift_o SHALL never be asserted in the same cycle; fifo_push_o MAY coincide with either.
REQ-030 DONE SHALL pulse done_o for 1 cycle and SHALL then transition to IDLE.
REQ-031 Row prefetch SHALL continue during STREAM and SHIFT so that, once the SA is stalled or the FIFO is full, no bubble exists between windows.
REQ-032 All counters SHALL be H_W+1 bits wide to avoid wrap when img_h = 2^H_W-1.

Reset
REQ-033 Asserting rst_async_n_i SHALL immediately force IDLE, clear all counters, and drive every output to 0.
REQ-034 A reset asserted mid-job SHALL abandon the job; no done_o SHALL follow, and the next job SHALL begin with FLUSH.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, COLUMN_FIFO_DEPTH and the K_MAX=7 constant.
REQ-036 The fetch engine SHALL be a sub-module named row_fetch_unit, which owns fetched, outstanding and the SRAM strobes.

Verification
REQ-037 Scenario: img_h=5, K=3, sa_ready_i=1 always -> 5 requests at addresses 0..4, three 3-pop bursts, 3 shifts, one done_o pulse; out_row_o = 0,1,2.
REQ-038 Scenario: start with K=0, or K=6 with img_h=4 -> err_o pulse, busy_o stays 0, no FIFO strobe.
REQ-039 Scenario: DEPTH=4, img_h=10, K=3, sa_ready_i toggling -> occ never exceeds 4, and no push occurs while fifo_full_i=1.
REQ-040 Scenario: reset asserted during the second STREAM -> all outputs 0 immediately; a restart issues fifo_flush_o and the sequence begins from row 0.
REQ-041 Scenario: K=1, img_h=1 -> 1 request, 1 pop, 1 shift, then done_o.
REQ-042 Scenario: start_i pulsed while busy -> ignored; exactly one done_o occurs.
